// File: rtl/vend_pkg.sv
// Shared state encoding and default sizing for the vending mode controller.
package vend_pkg;

  typedef enum logic [3:0] {
    ST_OFF        = 4'h0,
    ST_INQUIRE    = 4'h1,
    ST_PAYMENT    = 4'h2,
    ST_ADD_AMOUNT = 4'h3,
    ST_ADM_ITEM   = 4'h4,
    ST_ADM_MENU   = 4'h5,
    ST_SUCCESS    = 4'h6,
    ST_FAILURE    = 4'h7
  } state_t;

  localparam int N_ADM_DEF       = 3;
  localparam int PAY_TIMEOUT_DEF = 1000;

  function automatic logic is_user_state(input state_t s);
    return (s inside {ST_INQUIRE, ST_ADD_AMOUNT, ST_PAYMENT, ST_SUCCESS, ST_FAILURE});
  endfunction

  function automatic logic is_admin_state(input state_t s);
    return (s inside {ST_ADM_MENU, ST_ADM_ITEM});
  endfunction

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for W synchronous level inputs.
module edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] lvl,
  output logic [W-1:0] rise
);

  logic [W-1:0] lvl_q;

  // Cleared in reset so a level held across reset release reads as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_q <= '0;
    else        lvl_q <= lvl;
  end

  assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/vend_mode_ctrl.sv
// Vending machine mode controller: user purchase flow, admin menu cursor, payment timeout.
//
// state       | meaning
// ST_OFF      | machine powered down, cursor cleared
// ST_INQUIRE  | idle, waiting for the user to start
// ST_ADD_AMOUNT | user choosing amount
// ST_PAYMENT  | waiting for payment result, timeout running
// ST_SUCCESS  | payment accepted
// ST_FAILURE  | payment rejected, cancelled or timed out
// ST_ADM_MENU | admin browsing entries with plus/minus
// ST_ADM_ITEM | admin inside the selected entry
module vend_mode_ctrl
  import vend_pkg::*;
#(
  parameter  int N_ADM       = N_ADM_DEF,
  parameter  int PAY_TIMEOUT = PAY_TIMEOUT_DEF,
  localparam int SEL_W       = $clog2(N_ADM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             main_switch,
  input  logic             adm_mode,
  input  logic             btn_plus,
  input  logic             btn_minus,
  input  logic             btn_confirm,
  input  logic             btn_return,
  input  logic             pay_done,
  input  logic             pay_ok,
  output logic [3:0]       state,
  output logic [SEL_W-1:0] adm_sel,
  output logic             timeout
);

  localparam int CNT_W = $clog2(PAY_TIMEOUT);

  state_t           state_q, state_nxt;
  logic [SEL_W-1:0] sel_q, sel_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [3:0]       btn_rise;
  logic             pl, mi, cf, rt;
  logic             pay_last;
  logic             timeout_c;

  edge_det #(.W(4)) u_edge_det (
    .clk   (clk),
    .rst_n (rst_n),
    .lvl   ({btn_return, btn_confirm, btn_minus, btn_plus}),
    .rise  (btn_rise)
  );

  assign pl = btn_rise[0];
  assign mi = btn_rise[1];
  assign cf = btn_rise[2];
  assign rt = btn_rise[3];

  assign pay_last = (cnt_q == CNT_W'(PAY_TIMEOUT - 1));

  always_comb begin
    state_nxt = state_q;
    sel_nxt   = sel_q;
    timeout_c = 1'b0;
    if (!main_switch) begin
      state_nxt = ST_OFF;
    end else if (state_q == ST_OFF) begin
      state_nxt = adm_mode ? ST_ADM_MENU : ST_INQUIRE;
    end else if (is_user_state(state_q) && adm_mode) begin
      state_nxt = ST_ADM_MENU;
    end else if (is_admin_state(state_q) && !adm_mode) begin
      state_nxt = ST_INQUIRE;
    end else begin
      case (state_q)
        ST_INQUIRE: begin
          if (cf) state_nxt = ST_ADD_AMOUNT;
        end
        ST_ADD_AMOUNT: begin
          if (cf)      state_nxt = ST_PAYMENT;
          else if (rt) state_nxt = ST_INQUIRE;
        end
        ST_PAYMENT: begin
          // A payment result always beats a cancel or an expiring timer.
          if (pay_done) begin
            state_nxt = pay_ok ? ST_SUCCESS : ST_FAILURE;
          end else begin
            timeout_c = pay_last;
            if (rt || pay_last) state_nxt = ST_FAILURE;
          end
        end
        ST_SUCCESS, ST_FAILURE: begin
          if (cf || rt) state_nxt = ST_INQUIRE;
        end
        ST_ADM_MENU: begin
          if (cf) begin
            state_nxt = ST_ADM_ITEM;
          end else if (pl && !mi) begin
            sel_nxt = (sel_q == SEL_W'(N_ADM - 1)) ? '0 : sel_q + SEL_W'(1);
          end else if (mi && !pl) begin
            sel_nxt = (sel_q == '0) ? SEL_W'(N_ADM - 1) : sel_q - SEL_W'(1);
          end
        end
        ST_ADM_ITEM: begin
          if (rt) state_nxt = ST_ADM_MENU;
        end
        default: state_nxt = ST_OFF;
      endcase
    end
    if (state_nxt == ST_OFF) sel_nxt = '0;
  end

  // Counter only runs while staying in PAYMENT, so it is zero on the first PAYMENT cycle.
  always_comb begin
    cnt_nxt = '0;
    if ((state_q == ST_PAYMENT) && (state_nxt == ST_PAYMENT)) cnt_nxt = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      sel_q   <= sel_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  assign state   = state_q;
  assign adm_sel = sel_q;
  assign timeout = timeout_c;

endmodule

// File: tb/tb_vend_mode_ctrl.sv
// Scoreboard bench for vend_mode_ctrl: a reference model queues expected observations, a monitor checks them.
module tb_vend_mode_ctrl;

  localparam int NA = 3;
  localparam int PT = 8;

  localparam int S_OFF = 0, S_INQ = 1, S_PAY = 2, S_ADD = 3;
  localparam int S_ITEM = 4, S_MENU = 5, S_SUC = 6, S_FAIL = 7;

  localparam logic [3:0] B0 = 4'b0000;
  localparam logic [3:0] PL = 4'b0001;
  localparam logic [3:0] MI = 4'b0010;
  localparam logic [3:0] CF = 4'b0100;
  localparam logic [3:0] RT = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       main_switch = 1'b0, adm_mode = 1'b0;
  logic       btn_plus = 1'b0, btn_minus = 1'b0, btn_confirm = 1'b0, btn_return = 1'b0;
  logic       pay_done = 1'b0, pay_ok = 1'b0;
  logic [3:0] state;
  logic [1:0] adm_sel;
  logic       timeout;

  always #5 clk = ~clk;

  vend_mode_ctrl #(.N_ADM(NA), .PAY_TIMEOUT(PT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .main_switch (main_switch),
    .adm_mode    (adm_mode),
    .btn_plus    (btn_plus),
    .btn_minus   (btn_minus),
    .btn_confirm (btn_confirm),
    .btn_return  (btn_return),
    .pay_done    (pay_done),
    .pay_ok      (pay_ok),
    .state       (state),
    .adm_sel     (adm_sel),
    .timeout     (timeout)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] sel;
    logic       to;
  } obs_t;

  obs_t exp_q[$];
  obs_t last_push;
  int   checks = 0;
  int   failures = 0;

  // Reference model: current state, cursor, 1-based cycle index inside PAYMENT, previous button levels.
  int         m_st, m_sel, m_pay;
  int         n_st, n_sel, n_pay;
  logic [3:0] m_prev;
  bit         m_to;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_OFF; m_sel = 0; m_pay = 0;
    n_st = S_OFF; n_sel = 0; n_pay = 0;
    m_prev = 4'b0; m_to = 1'b0;
  endtask

  task automatic push_obs();
    obs_t o;
    o.st  = 4'(m_st);
    o.sel = 4'(m_sel);
    o.to  = m_to;
    if (o != last_push || o.to) begin
      exp_q.push_back(o);
      last_push = o;
    end
  endtask

  // Evaluates the cycle in progress from the currently driven inputs.
  task automatic evaluate();
    logic [3:0] e;
    bit pl, mi, cf, rt, user, admin;
    e  = {btn_return, btn_confirm, btn_minus, btn_plus} & ~m_prev;
    pl = e[0]; mi = e[1]; cf = e[2]; rt = e[3];
    user  = (m_st == S_INQ || m_st == S_ADD || m_st == S_PAY || m_st == S_SUC || m_st == S_FAIL);
    admin = (m_st == S_MENU || m_st == S_ITEM);
    n_st = m_st; n_sel = m_sel; m_to = 1'b0;
    if (!main_switch) n_st = S_OFF;
    else if (m_st == S_OFF) n_st = adm_mode ? S_MENU : S_INQ;
    else if (user && adm_mode) n_st = S_MENU;
    else if (admin && !adm_mode) n_st = S_INQ;
    else begin
      case (m_st)
        S_INQ: if (cf) n_st = S_ADD;
        S_ADD: n_st = cf ? S_PAY : (rt ? S_INQ : S_ADD);
        S_PAY: begin
          if (pay_done) n_st = pay_ok ? S_SUC : S_FAIL;
          else begin
            m_to = (m_pay == PT);
            if (m_to || rt) n_st = S_FAIL;
          end
        end
        S_SUC, S_FAIL: if (cf || rt) n_st = S_INQ;
        S_MENU: begin
          if (cf) n_st = S_ITEM;
          else if (pl && !mi) n_sel = (m_sel + 1) % NA;
          else if (mi && !pl) n_sel = (m_sel + NA - 1) % NA;
        end
        S_ITEM: if (rt) n_st = S_MENU;
        default: n_st = S_OFF;
      endcase
    end
    if (n_st == S_OFF) n_sel = 0;
    n_pay = (n_st == S_PAY) ? m_pay + 1 : 0;
    push_obs();
  endtask

  task automatic commit();
    m_st = n_st; m_sel = n_sel; m_pay = n_pay;
    m_prev = {btn_return, btn_confirm, btn_minus, btn_plus};
  endtask

  task automatic cyc(input bit ms, input bit am, input logic [3:0] b, input bit pd = 1'b0, input bit ok = 1'b0);
    @(posedge clk);
    commit();
    #1;
    main_switch = ms; adm_mode = am;
    {btn_return, btn_confirm, btn_minus, btn_plus} = b;
    pay_done = pd; pay_ok = ok;
    evaluate();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    evaluate();
  endtask

  task automatic reset_now();
    @(posedge clk);
    commit();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 32'(S_OFF));
    check("async_rst_sel", 32'(adm_sel), 0);
    check("async_rst_timeout", 32'(timeout), 0);
    model_reset();
    push_obs();
  endtask

  task automatic expect_state(input string nm, input int st);
    @(negedge clk);
    check(nm, 32'(state), 32'(st));
  endtask

  // Monitor: every change of the observable outputs, and every timeout pulse, is one DUT event.
  initial begin
    obs_t last, cur, exp;
    last = '0;
    forever begin
      @(negedge clk);
      cur = {state, 2'b00, adm_sel, timeout};
      if (cur != last || timeout) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL obs_unexpected: got st=%0d sel=%0d to=%0d expected no event", cur.st, cur.sel, cur.to);
        end else begin
          exp = exp_q.pop_front();
          if (cur !== exp) begin
            failures++;
            $display("FAIL obs: got st=%0d sel=%0d to=%0d expected st=%0d sel=%0d to=%0d",
                     cur.st, cur.sel, cur.to, exp.st, exp.sel, exp.to);
          end
        end
        last = cur;
      end
    end
  end

  initial begin
    model_reset();
    last_push = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_state", 32'(state), 32'(S_OFF));
    check("reset_sel", 32'(adm_sel), 0);
    check("reset_timeout", 32'(timeout), 0);
    repeat (3) @(posedge clk);
    release_reset();

    // Purchase flow: 1,3,2,6 then back to 1.
    cyc(1, 0, B0);
    cyc(1, 0, CF);
    cyc(1, 0, B0);
    cyc(1, 0, CF);
    cyc(1, 0, B0);
    cyc(1, 0, B0, 1, 1);
    cyc(1, 0, B0);
    expect_state("flow_success", S_SUC);
    cyc(1, 0, CF);
    cyc(1, 0, B0);
    expect_state("flow_back_inquire", S_INQ);

    // Admin cursor: plus x4 -> 1,2,0,1 ; minus x2 -> 0,2.
    cyc(1, 1, B0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, PL);
      cyc(1, 1, B0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, MI);
      cyc(1, 1, B0);
    end
    expect_state("adm_menu", S_MENU);
    check("adm_sel_after_walk", 32'(adm_sel), 2);
    cyc(1, 1, PL | MI);
    cyc(1, 1, CF);
    cyc(1, 1, PL);
    cyc(1, 1, RT);
    cyc(1, 1, B0);
    cyc(1, 0, B0);
    cyc(1, 0, B0);
    expect_state("adm_exit_inquire", S_INQ);
    check("adm_sel_retained", 32'(adm_sel), 2);

    // Confirm held for five cycles: only one advance.
    repeat (5) cyc(1, 0, CF);
    cyc(1, 0, B0);
    expect_state("held_confirm", S_ADD);

    // Payment timeout.
    cyc(1, 0, CF);
    repeat (10) cyc(1, 0, B0);
    expect_state("timeout_failure", S_FAIL);

    // pay_done with failure and return in the same cycle.
    cyc(1, 0, RT);
    cyc(1, 0, B0);
    cyc(1, 0, CF);
    cyc(1, 0, B0);
    cyc(1, 0, CF);
    cyc(1, 0, B0);
    cyc(1, 0, RT, 1, 0);
    cyc(1, 0, B0);
    expect_state("done_vs_return", S_FAIL);

    // Reset in the middle of PAYMENT, with a nonzero cursor.
    cyc(1, 0, CF);
    cyc(1, 0, B0);
    cyc(1, 0, CF);
    cyc(1, 0, B0);
    cyc(1, 0, CF);
    cyc(1, 0, B0);
    reset_now();
    btn_confirm = 1'b1;
    repeat (2) @(posedge clk);
    release_reset();
    cyc(1, 0, CF);
    cyc(1, 0, CF);
    cyc(1, 0, B0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit ms, am, pd, ok;
      logic [3:0] b;
      ms = ($urandom_range(0, 39) != 0);
      am = ($urandom_range(0, 19) == 0) ? ~adm_mode : adm_mode;
      b  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      pd = ($urandom_range(0, 9) == 0);
      ok = 1'($urandom_range(0, 1));
      cyc(ms, am, b, pd, ok);
    end

    cyc(1, 0, B0);
    cyc(1, 0, B0);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_mode_ctrl.md
VEND_MODE_CTRL -- requirements
Module: vend_mode_ctrl

Interface
REQ-001 SHALL have parameter N_ADM, default 3: number of admin menu entries, legal range 2..16.
REQ-002 SHALL have parameter PAY_TIMEOUT, default 1000: clock cycles allowed in PAYMENT before failure, legal range 2..2^20.
REQ-003 SHALL have localparam SEL_W = $clog2(N_ADM).
REQ-004 SHALL have ports, in this order:
  - clk  in  1  sole clock; one clock, all flops on the rising edge.
  - rst_n  in  1  reset; asynchronous, active-low.
  - main_switch  in  1  machine power level.
  - adm_mode  in  1  admin-mode level.
  - btn_plus, btn_minus, btn_confirm, btn_return  in  1 each  synchronous debounced levels.
  - pay_done  in  1  one-cycle pulse: payment finished.
  - pay_ok  in  1  payment result, qualified by pay_done.
  - state  out  4  registered current state code.
  - adm_sel  out  SEL_W  admin cursor index.
  - timeout  out  1  one-cycle pulse when PAYMENT times out.

Function
REQ-005 SHALL detect a button press as a rising edge: level is 1 this cycle and its registered copy is 0.
REQ-006 SHALL update state one clock edge after the cycle in which the qualifying input is sampled; no combinational path from inputs to state.
REQ-007 SHALL use these state codes: OFF 4'h0, INQUIRE 4'h1, ADD_AMOUNT 4'h3, PAYMENT 4'h2, SUCCESS 4'h6, FAILURE 4'h7, ADM_MENU 4'h5, ADM_ITEM 4'h4.
REQ-008 SHALL apply transition priority in this order:
  - main_switch=0: go to OFF from any state.
  - adm_mode=1 in a user state: go to ADM_MENU.
  - adm_mode=0 in an admin state: go to INQUIRE.
  - otherwise the per-state rules below.
REQ-009 SHALL go from OFF to INQUIRE when main_switch=1 and adm_mode=0, and from OFF to ADM_MENU when main_switch=1 and adm_mode=1.
REQ-010 SHALL go from INQUIRE to ADD_AMOUNT on confirm.
REQ-011 SHALL go from ADD_AMOUNT to PAYMENT on confirm and to INQUIRE on return; confirm wins if both occur in the same cycle.
REQ-012 SHALL go from PAYMENT to SUCCESS on pay_done&pay_ok, and to FAILURE on pay_done&!pay_ok, on return, or on timeout.
REQ-013 SHALL give pay_done priority over return and timeout when they coincide.
REQ-014 SHALL go from SUCCESS or FAILURE to INQUIRE on confirm or return.
REQ-015 SHALL handle adm_sel in ADM_MENU as follows:
  - plus increments adm_sel, wrapping N_ADM-1 to 0.
  - minus decrements adm_sel, wrapping 0 to N_ADM-1.
  - plus and minus together: no change.
  - confirm goes to ADM_ITEM and holds adm_sel.
REQ-016 SHALL go from ADM_ITEM to ADM_MENU on return; plus and minus are ignored in ADM_ITEM.
REQ-017 SHALL use a timeout counter that clears on entry to PAYMENT and increments every cycle in PAYMENT.
REQ-018 SHALL pulse timeout for exactly one cycle when the counter reaches PAY_TIMEOUT-1 without pay_done, with state=FAILURE on the next cycle.
REQ-019 SHALL hold the timeout counter at 0 outside PAYMENT.
REQ-020 SHALL treat any unused state code as OFF on the next clock.
REQ-021 SHALL clear adm_sel to 0 on entering OFF and retain it across INQUIRE↔admin transitions.

Reset
REQ-022 SHALL force, while rst_n=0 (asynchronously): state=OFF, adm_sel=0, timeout=0, timeout counter=0, all button edge registers=0.
REQ-023 SHALL register a button held high across reset release as an edge on the first cycle after release.
REQ-024 SHALL let reset asserted mid-PAYMENT abort it with no timeout pulse.

Structure
REQ-025 SHALL take the state codes (enum, 4-bit) and the default N_ADM and PAY_TIMEOUT constants from shared package vend_pkg.
REQ-026 SHALL instantiate sub-module edge_det (parameter W, async active-low reset) once with W=4 for the four buttons.
REQ-027 SHALL keep timeout counter width $clog2(PAY_TIMEOUT) and sel arithmetic in SEL_W bits with explicit wrap compare.

Verification
REQ-028 SHALL cover: reset, main_switch=1, confirm, confirm, pay_done=1 with pay_ok=1 -> state 1,3,2,6 on successive updates; confirm -> state 1.
REQ-029 SHALL cover: N_ADM=3, adm_mode=1, plus ×4 -> adm_sel 1,2,0,1; minus ×2 -> 0,2.
REQ-030 SHALL cover: PAY_TIMEOUT=8, enter PAYMENT, no pay_done -> timeout pulse on the 8th cycle in PAYMENT, state=7 next cycle.
REQ-031 SHALL cover: in PAYMENT, pay_done=1, pay_ok=0 and btn_return edge in the same cycle -> state=7 with timeout=0.
REQ-032 SHALL cover: btn_confirm held high for 5 cycles in INQUIRE -> exactly one transition to 3 and no advance to 2.
REQ-033 SHALL cover: rst_n=0 asserted mid-PAYMENT -> state=0 and adm_sel=0 immediately, without waiting for a clock edge.
